instr_decoder: RTL and testbench

RV32I + Zicsr decode stage with one output pipeline register. It sits between fetch and execute. It turns a 32-bit instruction word into the ALU operation code, operand-select controls, immediate, register indices and side-effect flags consumed by the execute stage. Both sides use a valid/ready handshake, and a flush input discards the held entry.

---
 rtl/instr_decoder_pkg.sv | 92 +++++++++
 rtl/instr_decoder_imm_gen.sv | 25 ++
 rtl/instr_decoder.sv | 230 +++++++++++++++++++++++
 tb/tb_instr_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decoder_pkg.sv
// Shared decode types: ALU operation codes, operand selects, opcodes and the
// decoded bundle carried from decode to execute.
package instr_decoder_pkg;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_SLTU  = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_AND   = 5'd9,
        ALU_EQ    = 5'd10,
        ALU_NE    = 5'd11,
        ALU_LT    = 5'd12,
        ALU_GE    = 5'd13,
        ALU_LTU   = 5'd14,
        ALU_GEU   = 5'd15,
        ALU_BIT_C = 5'd16
    } alu_op_t;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2,
        OP1_CSR  = 2'd3
    } op1_sel_t;

    typedef enum logic [1:0] {
        OP2_RS2 = 2'd0,
        OP2_IMM = 2'd1,
        OP2_RS1 = 2'd2
    } op2_sel_t;

    // Immediate format selector for imm_gen; IMM_Z is the CSR immediate form.
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        alu_op_t    alu_op;
        op1_sel_t   op1_sel;
        op2_sel_t   op2_sel;
        logic [31:0] imm;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] mem_size;
        logic       branch;
        logic       jump;
        logic       csr;
        logic       illegal;
    } decode_t;

    // funct3 to ALU op for OP/OP-IMM when funct7 selects the base variant.
    function automatic alu_op_t alu_arith(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_arith = ALU_ADD;
            3'b001:  alu_arith = ALU_SLL;
            3'b010:  alu_arith = ALU_SLT;
            3'b011:  alu_arith = ALU_SLTU;
            3'b100:  alu_arith = ALU_XOR;
            3'b101:  alu_arith = ALU_SRL;
            3'b110:  alu_arith = ALU_OR;
            default: alu_arith = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/instr_decoder_imm_gen.sv
// Immediate generator: builds the 32-bit immediate for the selected format.
module imm_gen
    import instr_decoder_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_t    fmt,
    output logic [31:0] imm
);

    // Format-specific bit gathering and extension
    always_comb begin
        imm = 32'h0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'h000};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            // CSR address in [11:0], zero-extended zimm in [16:12]
            IMM_Z: imm = {15'h0, instr[19:15], instr[31:20]};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/instr_decoder.sv
// RV32I + Zicsr decode stage with a single valid/ready output register.
module instr_decoder
    import instr_decoder_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  alu_ops,
    output logic [1:0]  op1_sel,
    output logic [1:0]  op2_sel,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [2:0]  mem_size,
    output logic        branch,
    output logic        jump,
    output logic        csr,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    imm_fmt_t    fmt;
    logic [31:0] imm_val;
    decode_t     ctrl;
    decode_t     dec_d;
    decode_t     dec_q;
    logic        valid_q;
    logic [31:0] pc_q;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm_val)
    );

    // Control decode; illegal encodings collapse to a side-effect-free ADD
    always_comb begin
        ctrl     = '0;
        fmt      = IMM_NONE;
        ctrl.rs1 = in_instr[19:15];
        ctrl.rs2 = in_instr[24:20];
        ctrl.rd  = in_instr[11:7];
        case (opcode)
            OPC_LUI: begin
                ctrl.op1_sel = OP1_ZERO;
                ctrl.op2_sel = OP2_IMM;
                ctrl.reg_we  = 1'b1;
                fmt          = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl.op1_sel = OP1_PC;
                ctrl.op2_sel = OP2_IMM;
                ctrl.reg_we  = 1'b1;
                fmt          = IMM_U;
            end
            OPC_JAL: begin
                ctrl.op1_sel = OP1_PC;
                ctrl.op2_sel = OP2_IMM;
                ctrl.reg_we  = 1'b1;
                ctrl.jump    = 1'b1;
                fmt          = IMM_J;
            end
            OPC_JALR: begin
                ctrl.op2_sel = OP2_IMM;
                ctrl.reg_we  = 1'b1;
                ctrl.jump    = 1'b1;
                fmt          = IMM_I;
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1;
                fmt         = IMM_B;
                case (f3)
                    3'b000:  ctrl.alu_op = ALU_EQ;
                    3'b001:  ctrl.alu_op = ALU_NE;
                    3'b100:  ctrl.alu_op = ALU_LT;
                    3'b101:  ctrl.alu_op = ALU_GE;
                    3'b110:  ctrl.alu_op = ALU_LTU;
                    3'b111:  ctrl.alu_op = ALU_GEU;
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl.op2_sel  = OP2_IMM;
                ctrl.reg_we   = 1'b1;
                ctrl.mem_rd   = 1'b1;
                ctrl.mem_size = f3;
                fmt           = IMM_I;
            end
            OPC_STORE: begin
                ctrl.op2_sel  = OP2_IMM;
                ctrl.mem_wr   = 1'b1;
                ctrl.mem_size = f3;
                fmt           = IMM_S;
            end
            OPC_OPIMM: begin
                ctrl.op2_sel = OP2_IMM;
                ctrl.reg_we  = 1'b1;
                fmt          = IMM_I;
                ctrl.alu_op  = alu_arith(f3);
                // Shift-immediates reuse imm[11:5] as a funct7 qualifier
                if (f3 == 3'b001 && f7 != 7'b0000000) begin
                    ctrl.illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'b0100000) begin
                        ctrl.alu_op = ALU_SRA;
                    end else if (f7 != 7'b0000000) begin
                        ctrl.illegal = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                ctrl.reg_we = 1'b1;
                if (f7 == 7'b0000000) begin
                    ctrl.alu_op = alu_arith(f3);
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    ctrl.alu_op = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    ctrl.alu_op = ALU_SRA;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                ctrl.csr     = 1'b1;
                ctrl.reg_we  = 1'b1;
                ctrl.op2_sel = f3[2] ? OP2_IMM : OP2_RS1;
                fmt          = f3[2] ? IMM_Z : IMM_I;
                case (f3[1:0])
                    2'b01: begin
                        ctrl.alu_op  = ALU_ADD;
                        ctrl.op1_sel = OP1_ZERO;
                    end
                    2'b10: begin
                        ctrl.alu_op  = ALU_OR;
                        ctrl.op1_sel = OP1_CSR;
                    end
                    2'b11: begin
                        ctrl.alu_op  = ALU_BIT_C;
                        ctrl.op1_sel = OP1_CSR;
                    end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            default: ctrl.illegal = 1'b1;
        endcase

        if (ctrl.illegal) begin
            ctrl.alu_op   = ALU_ADD;
            ctrl.op1_sel  = OP1_RS1;
            ctrl.op2_sel  = OP2_RS2;
            ctrl.reg_we   = 1'b0;
            ctrl.mem_rd   = 1'b0;
            ctrl.mem_wr   = 1'b0;
            ctrl.mem_size = 3'b000;
            ctrl.branch   = 1'b0;
            ctrl.jump     = 1'b0;
            ctrl.csr      = 1'b0;
            fmt           = IMM_NONE;
        end
        // x0 is never written
        if (ctrl.rd == 5'd0) begin
            ctrl.reg_we = 1'b0;
        end
    end

    // Merge the generated immediate into the bundle
    always_comb begin
        dec_d     = ctrl;
        dec_d.imm = imm_val;
    end

    assign in_ready = !valid_q || out_ready;

    // Output pipeline register: load on accept, clear on flush or drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            dec_q   <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (in_ready) begin
                valid_q <= in_valid;
            end
            if (in_valid && in_ready && !flush) begin
                pc_q  <= in_pc;
                dec_q <= dec_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = valid_q ? pc_q : RESET_PC;
    assign alu_ops   = dec_q.alu_op;
    assign op1_sel   = dec_q.op1_sel;
    assign op2_sel   = dec_q.op2_sel;
    assign imm       = dec_q.imm;
    assign rs1       = dec_q.rs1;
    assign rs2       = dec_q.rs2;
    assign rd        = dec_q.rd;
    assign reg_we    = dec_q.reg_we;
    assign mem_rd    = dec_q.mem_rd;
    assign mem_wr    = dec_q.mem_wr;
    assign mem_size  = dec_q.mem_size;
    assign branch    = dec_q.branch;
    assign jump      = dec_q.jump;
    assign csr       = dec_q.csr;
    assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: reference model plus directed vectors.
module tb_instr_decoder;
    import instr_decoder_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [4:0]  alu_ops, rs1, rs2, rd;
    logic [1:0]  op1_sel, op2_sel;
    logic [2:0]  mem_size;
    logic        reg_we, mem_rd, mem_wr, branch, jump, csr, illegal;

    int total = 0;
    int bad   = 0;

    instr_decoder #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_ops(alu_ops), .op1_sel(op1_sel), .op2_sel(op2_sel), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd), .reg_we(reg_we), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_size(mem_size), .branch(branch), .jump(jump),
        .csr(csr), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the ISA field rules
    function automatic decode_t model(input logic [31:0] w);
        decode_t  e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [12:0] b13;
        logic [20:0] j21;
        alu_op_t  arith [8];
        alu_op_t  brt [8];
        logic     ok;
        arith = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        brt   = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        e = '0;
        e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        ok = 1'b1;
        b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        if (op == 7'h37 || op == 7'h17) begin
            e.op1_sel = (op == 7'h37) ? OP1_ZERO : OP1_PC;
            e.op2_sel = OP2_IMM; e.reg_we = 1; e.imm = w & 32'hFFFF_F000;
        end else if (op == 7'h6F) begin
            e.op1_sel = OP1_PC; e.op2_sel = OP2_IMM; e.reg_we = 1; e.jump = 1;
            e.imm = 32'(signed'(j21));
        end else if (op == 7'h67 || op == 7'h03 || op == 7'h13) begin
            e.op2_sel = OP2_IMM; e.reg_we = 1; e.imm = 32'($signed(w) >>> 20);
            if (op == 7'h67) e.jump = 1;
            if (op == 7'h03) begin e.mem_rd = 1; e.mem_size = f3; end
            if (op == 7'h13) begin
                e.alu_op = arith[f3];
                if (f3 == 1 && f7 != 0) ok = 0;
                if (f3 == 5 && f7 == 7'h20) e.alu_op = ALU_SRA;
                else if (f3 == 5 && f7 != 0) ok = 0;
            end
        end else if (op == 7'h23) begin
            e.op2_sel = OP2_IMM; e.mem_wr = 1; e.mem_size = f3;
            e.imm = 32'($signed({f7, w[11:7], 20'h0}) >>> 20);
        end else if (op == 7'h63) begin
            e.branch = 1; e.alu_op = brt[f3]; e.imm = 32'(signed'(b13));
            if (f3 == 2 || f3 == 3) ok = 0;
        end else if (op == 7'h33) begin
            e.reg_we = 1; e.alu_op = arith[f3];
            if (f7 == 7'h20 && f3 == 0) e.alu_op = ALU_SUB;
            else if (f7 == 7'h20 && f3 == 5) e.alu_op = ALU_SRA;
            else if (f7 != 0) ok = 0;
        end else if (op == 7'h73) begin
            e.csr = 1; e.reg_we = 1;
            if (f3 == 1 || f3 == 5) begin e.alu_op = ALU_ADD; e.op1_sel = OP1_ZERO; end
            else if (f3 == 2 || f3 == 6) begin e.alu_op = ALU_OR; e.op1_sel = OP1_CSR; end
            else if (f3 == 3 || f3 == 7) begin e.alu_op = ALU_BIT_C; e.op1_sel = OP1_CSR; end
            else ok = 0;
            if (f3 >= 4) begin
                e.op2_sel = OP2_IMM; e.imm = (32'(w[19:15]) << 12) + 32'(w[31:20]);
            end else begin
                e.op2_sel = OP2_RS1; e.imm = 32'($signed(w) >>> 20);
            end
        end else begin
            ok = 0;
        end
        if (!ok) begin
            e = '0; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.illegal = 1;
        end
        if (e.rd == 0) e.reg_we = 0;
        return e;
    endfunction

    // Expected register contents, advanced from the handshake rules
    logic    m_valid;
    logic [31:0] m_pc;
    decode_t m_dec;
    logic    started = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pc    <= RST_PC;
            m_dec   <= '0;
        end else begin
            if (flush) m_valid <= 1'b0;
            else if (!m_valid || out_ready) m_valid <= in_valid;
            if (in_valid && (!m_valid || out_ready) && !flush) begin
                m_pc  <= in_pc;
                m_dec <= model(in_instr);
            end
        end
    end

    decode_t act;
    always_comb begin
        act          = '0;
        act.alu_op   = alu_op_t'(alu_ops);
        act.op1_sel  = op1_sel_t'(op1_sel);
        act.op2_sel  = op2_sel_t'(op2_sel);
        act.imm      = imm;
        act.rs1      = rs1;
        act.rs2      = rs2;
        act.rd       = rd;
        act.reg_we   = reg_we;
        act.mem_rd   = mem_rd;
        act.mem_wr   = mem_wr;
        act.mem_size = mem_size;
        act.branch   = branch;
        act.jump     = jump;
        act.csr      = csr;
        act.illegal  = illegal;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && started) begin
            chk("out_valid", 96'(out_valid), 96'(m_valid));
            chk("in_ready", 96'(in_ready), 96'(!m_valid || out_ready));
            chk("out_pc", 96'(out_pc), 96'(m_valid ? m_pc : RST_PC));
            if (m_valid) chk("decode", 96'(act), 96'(m_dec));
        end
    end

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        #3;
        chk("rst_valid", 96'(out_valid), 96'(0));
        chk("rst_pc", 96'(out_pc), 96'(RST_PC));
        chk("rst_bundle", 96'(act), 96'(0));
        chk("rst_in_ready", 96'(in_ready), 96'(1));
        #9 rst_n = 1'b1;
        started = 1'b1;

        drive(1, 32'h00500093, 32'h100, 1, 0);   // ADDI x1,x0,5
        chk("addi_valid", 96'(out_valid), 96'(1));
        chk("addi_alu", 96'(alu_ops), 96'(ALU_ADD));
        chk("addi_sel", 96'({op1_sel, op2_sel}), 96'({OP1_RS1, OP2_IMM}));
        chk("addi_imm", 96'(imm), 96'(5));
        chk("addi_rd_we", 96'({rd, reg_we}), 96'({5'd1, 1'b1}));

        drive(1, 32'h402081B3, 32'h104, 1, 0);   // SUB x3,x1,x2
        chk("sub_alu", 96'(alu_ops), 96'(ALU_SUB));
        chk("sub_fields", 96'({op2_sel, rs1, rs2}), 96'({OP2_RS2, 5'd1, 5'd2}));
        drive(1, 32'h0020E1B3, 32'h108, 1, 0);   // OR x3,x1,x2
        chk("or_alu", 96'(alu_ops), 96'(ALU_OR));
        chk("or_pc", 96'(out_pc), 96'(32'h108));

        drive(1, 32'hFE20CCE3, 32'h10C, 1, 0);   // BLT x1,x2,-8
        chk("blt_alu", 96'(alu_ops), 96'(ALU_LT));
        chk("blt_imm", 96'(imm), 96'(32'hFFFF_FFF8));
        chk("blt_br_we", 96'({branch, reg_we}), 96'({1'b1, 1'b0}));

        drive(1, 32'h0040A183, 32'h110, 1, 0);   // LW x3,4(x1)
        for (int i = 0; i < 3; i++) begin         // stall with ADD pending
            drive(1, 32'h002082B3, 32'h114, 0, 0);
            chk("stall_in_ready", 96'(in_ready), 96'(0));
            chk("stall_pc", 96'(out_pc), 96'(32'h110));
            chk("stall_memrd", 96'(mem_rd), 96'(1));
        end
        drive(1, 32'h002082B3, 32'h114, 1, 0);
        chk("unstall_pc", 96'(out_pc), 96'(32'h114));

        drive(1, 32'h0020C333, 32'h118, 0, 1);   // flush with held ADD and new XOR
        chk("flush_valid", 96'(out_valid), 96'(0));
        drive(0, 32'h0, 32'h0, 1, 0);
        chk("flush_after", 96'(out_valid), 96'(0));

        drive(1, 32'h00000000, 32'h11C, 1, 0);
        chk("zero_illegal", 96'(illegal), 96'(1));
        chk("zero_flags", 96'({reg_we, mem_rd, mem_wr, branch, jump, csr}), 96'(0));

        drive(1, 32'h300332F3, 32'h120, 1, 0);   // CSRRC x5,0x300,x6
        chk("csrrc_alu", 96'(alu_ops), 96'(ALU_BIT_C));
        chk("csrrc_sel", 96'({op1_sel, op2_sel, csr}), 96'({OP1_CSR, OP2_RS1, 1'b1}));
        chk("csrrc_addr", 96'(imm[11:0]), 96'(12'h300));

        drive(0, 32'h0, 32'h0, 1, 0);             // drain with no new input
        chk("drain_valid", 96'(out_valid), 96'(0));

        drive(1, 32'h40315093, 32'h130, 1, 0);   // SRAI
        chk("srai_alu", 96'(alu_ops), 96'(ALU_SRA));
        drive(1, 32'h20315093, 32'h134, 1, 0);   // bad shift funct7
        chk("srli_bad", 96'(illegal), 96'(1));
        drive(1, 32'h123453B7, 32'h138, 1, 0);   // LUI
        chk("lui_imm", 96'(imm), 96'(32'h1234_5000));
        drive(1, 32'h008000EF, 32'h13C, 1, 0);   // JAL x1,8
        chk("jal_imm_jump", 96'({imm, jump}), 96'({32'd8, 1'b1}));
        drive(1, 32'h0020A423, 32'h140, 1, 0);   // SW
        chk("sw_imm_wr", 96'({imm, mem_wr, mem_size}), 96'({32'd8, 1'b1, 3'b010}));
        drive(1, 32'h3002D073, 32'h144, 1, 0);   // CSRRWI x0
        chk("csrrwi_we", 96'({reg_we, op1_sel, op2_sel}), 96'({1'b0, OP1_ZERO, OP2_IMM}));
        chk("csrrwi_imm", 96'(imm), 96'(32'h0000_5300));
        drive(1, 32'h00202063, 32'h148, 1, 0);   // BRANCH funct3 010
        chk("br010_illegal", 96'({illegal, branch}), 96'({1'b1, 1'b0}));
        drive(1, 32'h00000073, 32'h14C, 1, 0);   // ECALL
        drive(1, 32'h022081B3, 32'h150, 1, 0);   // MUL
        drive(1, 32'h00008067, 32'h154, 1, 0);   // JALR x0,0(x1)
        drive(1, 32'h00400297, 32'h158, 1, 0);   // AUIPC x5,0x400

        drive(1, 32'h00500093, 32'h200, 1, 0);
        drive(1, 32'h0020C333, 32'h204, 0, 0);   // stall
        #3 rst_n = 1'b0;
        #1 chk("async_rst_valid", 96'(out_valid), 96'(0));
        chk("async_rst_pc", 96'(out_pc), 96'(RST_PC));
        #3 rst_n = 1'b1;
        drive(0, 32'h0, 32'h0, 1, 0);
        chk("post_rst_valid", 96'(out_valid), 96'(0));
        drive(1, 32'h0020C333, 32'h208, 1, 0);
        chk("post_rst_xor", 96'(alu_ops), 96'(ALU_XOR));
        drive(0, 32'h0, 32'h0, 1, 0);
        drive(0, 32'h0, 32'h0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
